// File: rtl/axi4_w_buffer_drop_if.sv
// W-channel bundle around the write-data buffer: upstream W, downstream W,
// the per-burst decision port and the drop/fill status signals.
interface axi4_w_buffer_drop_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 2,
  parameter int DEPTH          = 4
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb;
  logic                        s_axi4_wlast;
  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser;
  logic                        s_axi4_wvalid;
  logic                        s_axi4_wready;

  logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb;
  logic                        m_axi4_wlast;
  logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser;
  logic                        m_axi4_wvalid;
  logic                        m_axi4_wready;

  logic                        cmd_valid;
  logic                        cmd_drop;
  logic                        cmd_ready;
  logic                        drop_done;
  logic [FW-1:0]               fill_level;

  // slave: the buffer itself; master: whatever drives and observes it
  modport slave (
    input  s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast, s_axi4_wuser, s_axi4_wvalid,
    output s_axi4_wready,
    output m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wuser, m_axi4_wvalid,
    input  m_axi4_wready,
    input  cmd_valid, cmd_drop,
    output cmd_ready, drop_done, fill_level
  );

  modport master (
    output s_axi4_wdata, s_axi4_wstrb, s_axi4_wlast, s_axi4_wuser, s_axi4_wvalid,
    input  s_axi4_wready,
    input  m_axi4_wdata, m_axi4_wstrb, m_axi4_wlast, m_axi4_wuser, m_axi4_wvalid,
    output m_axi4_wready,
    output cmd_valid, cmd_drop,
    input  cmd_ready, drop_done, fill_level
  );
endinterface

// File: rtl/axi4_w_buffer_drop.sv
// AXI4 W-path buffer: beats queue in a data FIFO, each queued decision either
// forwards or silently consumes exactly one wlast-terminated burst.
module axi4_w_buffer_drop #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 2,
  parameter int DEPTH          = 4,
  parameter int CMD_DEPTH      = 4
) (
  input logic                  axi4_aclk,
  input logic                  axi4_arst,
  axi4_w_buffer_drop_if.slave  bus
);
  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int CPW = $clog2(CMD_DEPTH) + 1;
  localparam int SW  = AXI_DATA_WIDTH / 8;

  typedef struct packed {
    logic [AXI_USER_WIDTH-1:0] user;
    logic [SW-1:0]             strb;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic                      last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t         state;
  beat_t          mem [DEPTH];
  beat_t          beat_in, head;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           full, empty, push, pop;

  logic           cmem [CMD_DEPTH];
  logic [CPW-1:0] cwr_ptr, crd_ptr;
  logic           cfull, cempty, cpush, cpop, cmd_head;

  // data FIFO: extra pointer MSB distinguishes full from empty
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign beat_in = {bus.s_axi4_wuser, bus.s_axi4_wstrb, bus.s_axi4_wdata, bus.s_axi4_wlast};
  assign head    = mem[rd_ptr[PW-2:0]];

  assign bus.s_axi4_wready = !axi4_arst && !full;
  assign push              = bus.s_axi4_wvalid && bus.s_axi4_wready;
  assign pop               = !empty && ((state == DROP) || ((state == FWD) && bus.m_axi4_wready));

  assign cfull    = (cwr_ptr[CPW-1] != crd_ptr[CPW-1]) && (cwr_ptr[CPW-2:0] == crd_ptr[CPW-2:0]);
  assign cempty   = (cwr_ptr == crd_ptr);
  assign cmd_head = cmem[crd_ptr[CPW-2:0]];

  assign bus.cmd_ready = !axi4_arst && !cfull;
  assign cpush         = bus.cmd_valid && bus.cmd_ready;
  assign cpop          = (state == IDLE) && !cempty;

  // output side reads straight from the FIFO head, so fields hold until popped
  assign bus.m_axi4_wvalid = (state == FWD) && !empty;
  assign bus.m_axi4_wdata  = head.data;
  assign bus.m_axi4_wstrb  = head.strb;
  assign bus.m_axi4_wlast  = head.last;
  assign bus.m_axi4_wuser  = head.user;
  assign bus.fill_level    = wr_ptr - rd_ptr;

  always_ff @(posedge axi4_aclk) begin
    if (push)  mem[wr_ptr[PW-2:0]]    <= beat_in;
    if (cpush) cmem[cwr_ptr[CPW-2:0]] <= bus.cmd_drop;
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cwr_ptr <= '0;
      crd_ptr <= '0;
    end else begin
      if (push)  wr_ptr  <= wr_ptr + 1'b1;
      if (pop)   rd_ptr  <= rd_ptr + 1'b1;
      if (cpush) cwr_ptr <= cwr_ptr + 1'b1;
      if (cpop)  crd_ptr <= crd_ptr + 1'b1;
    end
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      state         <= IDLE;
      bus.drop_done <= 1'b0;
    end else begin
      bus.drop_done <= 1'b0;
      case (state)
        IDLE: if (!cempty) state <= cmd_head ? DROP : FWD;
        FWD:  if (pop && head.last) state <= IDLE;
        DROP: if (pop && head.last) begin
          state         <= IDLE;
          bus.drop_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_w_buffer_drop.sv
// Directed bench for axi4_w_buffer_drop: forward, backpressure, drop, mixed
// ordering, pointer wrap under random handshakes, and mid-burst reset.
module tb_axi4_w_buffer_drop;
  localparam int DW = 32, UW = 2, DEPTH = 4, CD = 4;

  typedef struct packed {
    logic [UW-1:0]   user;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]   data;
    logic            last;
  } tb_beat_t;

  logic axi4_aclk = 1'b0;
  logic axi4_arst = 1'b1;
  always #5 axi4_aclk = ~axi4_aclk;

  axi4_w_buffer_drop_if #(.AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .DEPTH(DEPTH)) bus ();

  axi4_w_buffer_drop #(
    .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .DEPTH(DEPTH), .CMD_DEPTH(CD)
  ) dut (
    .axi4_aclk(axi4_aclk),
    .axi4_arst(axi4_arst),
    .bus      (bus)
  );

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // master-side monitor, sampled mid-cycle
  tb_beat_t q[$];
  tb_beat_t mb;
  int wv_cnt = 0, dd_cnt = 0, max_fill = 0;
  always @(negedge axi4_aclk) if (!axi4_arst) begin
    if (bus.m_axi4_wvalid) begin
      wv_cnt++;
      if (bus.m_axi4_wready) begin
        mb = {bus.m_axi4_wuser, bus.m_axi4_wstrb, bus.m_axi4_wdata, bus.m_axi4_wlast};
        q.push_back(mb);
      end
    end
    if (bus.drop_done) dd_cnt++;
    if (int'(bus.fill_level) > max_fill) max_fill = int'(bus.fill_level);
  end

  function automatic tb_beat_t mk(input logic [31:0] d, input logic l, input logic [1:0] u,
                                  input logic [3:0] s);
    tb_beat_t b;
    b.user = u; b.strb = s; b.data = d; b.last = l;
    return b;
  endfunction

  task automatic step();
    @(posedge axi4_aclk); #1;
  endtask

  task automatic push_beat(input tb_beat_t b);
    int t = 0;
    bus.s_axi4_wvalid = 1'b1;
    bus.s_axi4_wdata  = b.data;
    bus.s_axi4_wstrb  = b.strb;
    bus.s_axi4_wuser  = b.user;
    bus.s_axi4_wlast  = b.last;
    do begin @(negedge axi4_aclk); t++; end while (!bus.s_axi4_wready && t < 300);
    if (t >= 300) chk("push_timeout", 64'd0, 64'd1);
    step();
    bus.s_axi4_wvalid = 1'b0;
  endtask

  task automatic push_cmd(input logic drop);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_drop  = drop;
    do begin @(negedge axi4_aclk); t++; end while (!bus.cmd_ready && t < 300);
    if (t >= 300) chk("cmd_timeout", 64'd0, 64'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_q(input string tag, input tb_beat_t exp [$]);
    chk({tag, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), q[i], exp[i]);
  endtask

  tb_beat_t ea [$];
  tb_beat_t eb [$];
  tb_beat_t exp_q [$];
  int wv0, dd0;
  bit done;

  initial begin
    bus.s_axi4_wvalid = 0; bus.s_axi4_wdata = '0; bus.s_axi4_wstrb = '0;
    bus.s_axi4_wlast = 0; bus.s_axi4_wuser = '0; bus.m_axi4_wready = 0;
    bus.cmd_valid = 0; bus.cmd_drop = 0;

    // reset state
    repeat (2) @(posedge axi4_aclk);
    @(negedge axi4_aclk);
    chk("rst_wvalid", bus.m_axi4_wvalid, 0);
    chk("rst_wready", bus.s_axi4_wready, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_drop_done", bus.drop_done, 0);
    chk("rst_fill", bus.fill_level, 0);
    step();
    axi4_arst = 1'b0;
    @(negedge axi4_aclk);
    chk("rel_wready", bus.s_axi4_wready, 1);
    chk("rel_fill", bus.fill_level, 0);

    // forward: 4 beats queued ahead of the decision, master always ready
    step();
    bus.m_axi4_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ea.push_back(mk(32'hA0A0_0000 + i, i == 3, 2'(i), 4'hF - 4'(i)));
      push_beat(ea[i]);
    end
    @(negedge axi4_aclk);
    chk("fwd_fill4", bus.fill_level, 4);
    chk("fwd_full_wready", bus.s_axi4_wready, 0);
    step();
    bus.cmd_valid = 1'b1; bus.cmd_drop = 1'b0;
    @(negedge axi4_aclk);
    chk("fwd_cmd_ready", bus.cmd_ready, 1);
    chk("fwd_v0", bus.m_axi4_wvalid, 0);
    step();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge axi4_aclk);
      chk($sformatf("fwd_v%0d", k), bus.m_axi4_wvalid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5)
        chk($sformatf("fwd_beat%0d", k - 2),
            {bus.m_axi4_wuser, bus.m_axi4_wstrb, bus.m_axi4_wdata, bus.m_axi4_wlast}, ea[k-2]);
    end
    chk("fwd_fill0", bus.fill_level, 0);

    // backpressure: master stalled, 5-beat burst
    step();
    q.delete();
    bus.m_axi4_wready = 1'b0;
    push_cmd(1'b0);
    for (int i = 0; i < 5; i++) eb.push_back(mk(32'hB0B0_0000 + i, i == 4, 2'(3 - i), 4'(1 << (i % 4))));
    for (int i = 0; i < 4; i++) push_beat(eb[i]);
    bus.s_axi4_wvalid = 1'b1; bus.s_axi4_wdata = eb[4].data; bus.s_axi4_wstrb = eb[4].strb;
    bus.s_axi4_wuser = eb[4].user; bus.s_axi4_wlast = eb[4].last;
    @(negedge axi4_aclk);
    chk("bp_wready_low", bus.s_axi4_wready, 0);
    chk("bp_fill4", bus.fill_level, 4);
    chk("bp_wvalid", bus.m_axi4_wvalid, 1);
    chk("bp_head", bus.m_axi4_wdata, eb[0].data);
    step();
    @(negedge axi4_aclk);
    chk("bp_head_stable", bus.m_axi4_wdata, eb[0].data);
    chk("bp_fill_stable", bus.fill_level, 4);
    step();
    bus.m_axi4_wready = 1'b1;
    push_beat(eb[4]);
    repeat (8) step();
    check_q("bp", eb);
    chk("bp_fill0", bus.fill_level, 0);

    // drop: 3-beat burst never reaches the master
    q.delete();
    wv0 = wv_cnt; dd0 = dd_cnt;
    push_cmd(1'b1);
    push_beat(mk(32'hD000_0001, 0, 2'd1, 4'h3));
    push_beat(mk(32'hD000_0002, 0, 2'd2, 4'hC));
    push_beat(mk(32'hD000_0003, 1, 2'd3, 4'hF));
    @(negedge axi4_aclk);
    chk("drop_dd_before", bus.drop_done, 0);
    chk("drop_fill1", bus.fill_level, 1);
    @(negedge axi4_aclk);
    chk("drop_dd_pulse", bus.drop_done, 1);
    chk("drop_fill0", bus.fill_level, 0);
    @(negedge axi4_aclk);
    chk("drop_dd_after", bus.drop_done, 0);
    step();
    chk("drop_no_wvalid", wv_cnt - wv0, 0);
    chk("drop_pulses", dd_cnt - dd0, 1);

    // mixed: fwd, drop, fwd with data for two bursts ahead of the decisions
    q.delete();
    dd0 = dd_cnt;
    exp_q = '{mk(32'h1111_0000, 0, 2'd0, 4'hF), mk(32'h1111_0001, 1, 2'd1, 4'hE),
              mk(32'h3333_0000, 0, 2'd2, 4'h7), mk(32'h3333_0001, 1, 2'd3, 4'h1)};
    push_beat(exp_q[0]);
    push_beat(exp_q[1]);
    push_beat(mk(32'h2222_0000, 0, 2'd0, 4'h5));
    push_beat(mk(32'h2222_0001, 1, 2'd0, 4'h5));
    push_cmd(1'b0);
    push_cmd(1'b1);
    push_cmd(1'b0);
    push_beat(exp_q[2]);
    push_beat(exp_q[3]);
    repeat (20) step();
    check_q("mix", exp_q);
    chk("mix_pulses", dd_cnt - dd0, 1);

    // wrap: 12 beats in 3-beat bursts, random source gaps and master ready
    q.delete();
    max_fill = 0;
    exp_q.delete();
    for (int i = 0; i < 3 * DEPTH; i++)
      exp_q.push_back(mk(32'hC0DE_0000 + 32'(i) * 32'h111, (i % 3) == 2, 2'(i % 4), 4'(i % 16)));
    for (int i = 0; i < DEPTH; i++) push_cmd(1'b0);
    done = 0;
    fork
      begin
        int t = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
          repeat ($urandom_range(0, 2)) step();
          push_beat(exp_q[i]);
        end
        while (q.size() < 3 * DEPTH && t < 400) begin step(); t++; end
        done = 1;
      end
      begin
        while (!done) begin
          step();
          bus.m_axi4_wready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.m_axi4_wready = 1'b1;
    step();
    check_q("wrap", exp_q);
    chk("wrap_maxfill_ok", (max_fill <= DEPTH), 1);
    chk("wrap_fill0", bus.fill_level, 0);

    // reset mid-burst: buffered beats and the pending decision are discarded
    bus.m_axi4_wready = 1'b0;
    push_cmd(1'b0);
    push_beat(mk(32'hEEEE_0000, 0, 2'd0, 4'hF));
    push_beat(mk(32'hEEEE_0001, 0, 2'd0, 4'hF));
    @(negedge axi4_aclk);
    chk("mid_wvalid", bus.m_axi4_wvalid, 1);
    step();
    axi4_arst = 1'b1;
    @(negedge axi4_aclk);
    chk("mid_rst_wvalid", bus.m_axi4_wvalid, 0);
    chk("mid_rst_wready", bus.s_axi4_wready, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    chk("mid_rst_drop_done", bus.drop_done, 0);
    chk("mid_rst_fill", bus.fill_level, 0);
    step();
    axi4_arst = 1'b0;
    @(negedge axi4_aclk);
    chk("mid_rel_wready", bus.s_axi4_wready, 1);
    chk("mid_rel_fill", bus.fill_level, 0);
    chk("mid_rel_cmd_ready", bus.cmd_ready, 1);
    step();
    bus.m_axi4_wready = 1'b1;
    wv0 = wv_cnt; dd0 = dd_cnt;
    push_beat(mk(32'hF000_0000, 1, 2'd0, 4'hF));
    repeat (4) step();
    chk("mid_no_stale_cmd", wv_cnt - wv0, 0);
    chk("mid_no_drop_done", dd_cnt - dd0, 0);
    chk("mid_fill1", bus.fill_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
